// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: hazard and sequencing controller for the five pipeline
// registers (PC, IF/ID, ID/EX, EX/MEM, MEM/WB).
// It generates per-stage load enables and bubble flushes to handle load-use
// hazards, taken branches, a fixed-latency MDU and data-memory wait.
// Optional feature: define PIPE_HAZARD_STALL_CNT_EN to add a saturating
// 32-bit stall_cycles counter of cycles with pc_en low.
module pipe_hazard_ctrl #(
  parameter int REG_W   = 5,
  parameter int MDU_LAT = 4,
  parameter int CNT_W   = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             branch_taken,
  input  logic             mdu_start,
  input  logic             mem_wait,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             id_ex_en,
  output logic             ex_mem_en,
  output logic             mem_wb_en,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_mem_flush,
  output logic             mem_wb_flush,
  output logic             mdu_done
`ifdef PIPE_HAZARD_STALL_CNT_EN
  ,
  output logic [31:0]      stall_cycles
`endif
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MDU_BUSY = 2'd1,
    MDU_DONE = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             load_use;
  logic             mdu_freeze;

  // Load-use: a load in EX writes a register the ID instruction reads.
  // Register 0 is never a real dependency.
  always_comb begin
    load_use = ex_mem_read && (ex_rd != '0) &&
               ((id_uses_rs && (id_rs == ex_rd)) ||
                (id_uses_rt && (id_rt == ex_rd)));
    mdu_freeze = ((state == RUN) && mdu_start) || (state == MDU_BUSY);
  end

  // Priority resolution of the stage controls: memory wait, then MDU freeze,
  // then taken branch, then load-use; everything is zero while in reset.
  always_comb begin
    pc_en        = 1'b1;
    if_id_en     = 1'b1;
    id_ex_en     = 1'b1;
    ex_mem_en    = 1'b1;
    mem_wb_en    = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    mem_wb_flush = 1'b0;
    mdu_done     = 1'b0;
    if (!reset) begin
      pc_en     = 1'b0;
      if_id_en  = 1'b0;
      id_ex_en  = 1'b0;
      ex_mem_en = 1'b0;
      mem_wb_en = 1'b0;
    end else if (mem_wait) begin
      // Hold everything up to EX/MEM; push a bubble into MEM/WB.
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_ex_en     = 1'b0;
      ex_mem_en    = 1'b0;
      mem_wb_flush = 1'b1;
    end else if (mdu_freeze) begin
      // MDU op sits in EX; drain older instructions, bubble into EX/MEM.
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_ex_en     = 1'b0;
      ex_mem_flush = 1'b1;
    end else begin
      mdu_done = (state == MDU_DONE);
      if (branch_taken) begin
        // The ID instruction is killed, so a coincident load-use is moot.
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
      end else if (load_use) begin
        pc_en       = 1'b0;
        if_id_en    = 1'b0;
        id_ex_flush = 1'b1;
      end
    end
  end

  // MDU sequencer: count down the frozen cycles, then hold the done state
  // until memory is ready so the result pulse is never lost.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      case (state)
        RUN: begin
          if (mdu_start && !mem_wait) begin
            cnt   <= CNT_W'(MDU_LAT - 1);
            state <= (MDU_LAT > 1) ? MDU_BUSY : MDU_DONE;
          end
        end
        MDU_BUSY: begin
          cnt <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) begin
            state <= MDU_DONE;
          end
        end
        MDU_DONE: begin
          if (!mem_wait) begin
            state <= RUN;
          end
        end
        default: begin
          state <= RUN;
          cnt   <= '0;
        end
      endcase
    end
  end

`ifdef PIPE_HAZARD_STALL_CNT_EN
  // Count cycles with the PC held, saturating at all-ones.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stall_cycles <= '0;
    end else if (!pc_en && (stall_cycles != 32'hFFFF_FFFF)) begin
      stall_cycles <= stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: drives two controllers (MDU_LAT 4 and MDU_LAT 2) with
// the same inputs and compares both against a behavioural reference model.
// Honours PIPE_HAZARD_STALL_CNT_EN for the optional stall counter.
module tb_pipe_hazard_ctrl;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [4:0] id_rs = '0;
  logic [4:0] id_rt = '0;
  logic       id_uses_rs = 1'b0;
  logic       id_uses_rt = 1'b0;
  logic       ex_mem_read = 1'b0;
  logic [4:0] ex_rd = '0;
  logic       branch_taken = 1'b0;
  logic       mdu_start = 1'b0;
  logic       mem_wait = 1'b0;

  logic pc_en4, if_id_en4, id_ex_en4, ex_mem_en4, mem_wb_en4;
  logic if_id_fl4, id_ex_fl4, ex_mem_fl4, mem_wb_fl4, done4;
  logic pc_en2, if_id_en2, id_ex_en2, ex_mem_en2, mem_wb_en2;
  logic if_id_fl2, id_ex_fl2, ex_mem_fl2, mem_wb_fl2, done2;
`ifdef PIPE_HAZARD_STALL_CNT_EN
  logic [31:0] stall4, stall2;
`endif

  int vectors = 0;
  int miscompares = 0;

  // Reference model state per instance: frozen cycles still to come after
  // the start cycle, and whether a done pulse is owed.
  int lat [2] = '{4, 2};
  int frz [2] = '{0, 0};
  bit dpend [2] = '{1'b0, 1'b0};

  always #5 clock = ~clock;

  pipe_hazard_ctrl #(.REG_W(5), .MDU_LAT(4), .CNT_W(4)) u_dut4 (
    .clock(clock), .reset(reset), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .branch_taken(branch_taken),
    .mdu_start(mdu_start), .mem_wait(mem_wait),
    .pc_en(pc_en4), .if_id_en(if_id_en4), .id_ex_en(id_ex_en4),
    .ex_mem_en(ex_mem_en4), .mem_wb_en(mem_wb_en4),
    .if_id_flush(if_id_fl4), .id_ex_flush(id_ex_fl4),
    .ex_mem_flush(ex_mem_fl4), .mem_wb_flush(mem_wb_fl4), .mdu_done(done4)
`ifdef PIPE_HAZARD_STALL_CNT_EN
    , .stall_cycles(stall4)
`endif
  );

  pipe_hazard_ctrl #(.REG_W(5), .MDU_LAT(2), .CNT_W(2)) u_dut2 (
    .clock(clock), .reset(reset), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .branch_taken(branch_taken),
    .mdu_start(mdu_start), .mem_wait(mem_wait),
    .pc_en(pc_en2), .if_id_en(if_id_en2), .id_ex_en(id_ex_en2),
    .ex_mem_en(ex_mem_en2), .mem_wb_en(mem_wb_en2),
    .if_id_flush(if_id_fl2), .id_ex_flush(id_ex_fl2),
    .ex_mem_flush(ex_mem_fl2), .mem_wb_flush(mem_wb_fl2), .mdu_done(done2)
`ifdef PIPE_HAZARD_STALL_CNT_EN
    , .stall_cycles(stall2)
`endif
  );

  // Observed vector layout: {pc,if_id,id_ex,ex_mem,mem_wb en; if_id,id_ex,ex_mem,mem_wb flush; done}
  function automatic logic [9:0] obs(int k);
    if (k == 0)
      return {pc_en4, if_id_en4, id_ex_en4, ex_mem_en4, mem_wb_en4,
              if_id_fl4, id_ex_fl4, ex_mem_fl4, mem_wb_fl4, done4};
    return {pc_en2, if_id_en2, id_ex_en2, ex_mem_en2, mem_wb_en2,
            if_id_fl2, id_ex_fl2, ex_mem_fl2, mem_wb_fl2, done2};
  endfunction

  // Expected controls from the priority rules, using the model's phase.
  function automatic logic [9:0] model_out(int k);
    bit lu, idle;
    if (!reset) return 10'b0;
    lu = ex_mem_read && (ex_rd != 0) &&
         ((id_uses_rs && id_rs == ex_rd) || (id_uses_rt && id_rt == ex_rd));
    idle = (frz[k] == 0) && !dpend[k];
    if (mem_wait) return 10'b00001_0001_0;
    if ((idle && mdu_start) || frz[k] > 0) return 10'b00011_0010_0;
    if (branch_taken) return {10'b11111_1100_0} | {9'b0, dpend[k]};
    if (lu) return {10'b00111_0100_0} | {9'b0, dpend[k]};
    return {10'b11111_0000_0} | {9'b0, dpend[k]};
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      frz[k] = 0;
      dpend[k] = 1'b0;
    end
  endtask

  // Advance the model across a rising edge using the inputs held there.
  task automatic tick();
    @(posedge clock);
    for (int k = 0; k < 2; k++) begin
      if (!reset) begin
        frz[k] = 0;
        dpend[k] = 1'b0;
      end else if (frz[k] == 0 && !dpend[k] && mdu_start && !mem_wait) begin
        frz[k] = lat[k] - 1;
        if (frz[k] == 0) dpend[k] = 1'b1;
      end else if (frz[k] > 0) begin
        frz[k] = frz[k] - 1;
        if (frz[k] == 0) dpend[k] = 1'b1;
      end else if (dpend[k] && !mem_wait) begin
        dpend[k] = 1'b0;
      end
    end
  endtask

  task automatic drive(input bit mr, input logic [4:0] rd, input logic [4:0] rs,
                       input logic [4:0] rt, input bit urs, input bit urt,
                       input bit br, input bit ms, input bit mw);
    ex_mem_read = mr; ex_rd = rd; id_rs = rs; id_rt = rt;
    id_uses_rs = urs; id_uses_rt = urt;
    branch_taken = br; mdu_start = ms; mem_wait = mw;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      tick();
    end
  endtask

  // Outputs are all zero in reset, and default enables follow release.
  task automatic test_reset();
    logic [9:0] got;
    #2;
    for (int k = 0; k < 2; k++) begin
      got = obs(k); vectors++;
      if (got !== 10'b0) begin
        miscompares++;
        $display("[TB] FAIL reset_hold dut%0d: got %b expected %b", k, got, 10'b0);
      end
    end
    tick();
    @(negedge clock);
    reset = 1'b1;
    #2;
    for (int k = 0; k < 2; k++) begin
      got = obs(k); vectors++;
      if (got !== 10'b11111_0000_0) begin
        miscompares++;
        $display("[TB] FAIL reset_release dut%0d: got %b expected %b", k, got, 10'b11111_0000_0);
      end
    end
    tick();
  endtask

  // Load-use stall, its release, and the r0 exemption.
  task automatic test_load_use();
    logic [9:0] got, exp;
    for (int c = 0; c < 4; c++) begin
      @(negedge clock);
      case (c)
        0: drive(1, 5, 5, 0, 1, 0, 0, 0, 0);
        1: drive(0, 5, 5, 0, 1, 0, 0, 0, 0);
        2: drive(1, 0, 0, 0, 1, 0, 0, 0, 0);
        default: drive(1, 7, 1, 7, 0, 1, 0, 0, 0);
      endcase
      #2;
      for (int k = 0; k < 2; k++) begin
        exp = model_out(k); got = obs(k); vectors++;
        if (got !== exp) begin
          miscompares++;
          $display("[TB] FAIL load_use c%0d dut%0d: got %b expected %b", c, k, got, exp);
        end
      end
      tick();
    end
  endtask

  // mdu_start held continuously: freeze, done pulse, immediate restart.
  task automatic test_mdu();
    logic [9:0] got, exp;
    for (int c = 0; c < 13; c++) begin
      @(negedge clock);
      drive(0, 0, 0, 0, 0, 0, 0, (c < 7), 0);
      #2;
      for (int k = 0; k < 2; k++) begin
        exp = model_out(k); got = obs(k); vectors++;
        if (got !== exp) begin
          miscompares++;
          $display("[TB] FAIL mdu c%0d dut%0d: got %b expected %b", c, k, got, exp);
        end
      end
      tick();
    end
  endtask

  // Branch and load-use together: branch flush wins, no stall.
  task automatic test_branch_lu();
    logic [9:0] got, exp;
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      drive(1, 3, 3, 3, 1, 1, (c != 2), 0, 0);
      #2;
      for (int k = 0; k < 2; k++) begin
        exp = model_out(k); got = obs(k); vectors++;
        if (got !== exp) begin
          miscompares++;
          $display("[TB] FAIL branch_lu c%0d dut%0d: got %b expected %b", c, k, got, exp);
        end
      end
      tick();
    end
  endtask

  // Memory wait across an MDU op: done is held until memory is ready.
  task automatic test_mem_wait_mdu();
    logic [9:0] got, exp;
    for (int c = 0; c < 8; c++) begin
      @(negedge clock);
      drive(0, 0, 0, 0, 0, 0, (c == 4), (c == 0), (c >= 1 && c <= 3));
      #2;
      for (int k = 0; k < 2; k++) begin
        exp = model_out(k); got = obs(k); vectors++;
        if (got !== exp) begin
          miscompares++;
          $display("[TB] FAIL mem_wait_mdu c%0d dut%0d: got %b expected %b", c, k, got, exp);
        end
      end
      tick();
    end
  endtask

  // Reset asserted in the middle of an MDU op abandons it.
  task automatic test_reset_mid_mdu();
    logic [9:0] got, exp;
    for (int c = 0; c < 2; c++) begin
      @(negedge clock);
      drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
      tick();
    end
    @(negedge clock);
    reset = 1'b0;
    model_reset();
    #1;
    for (int k = 0; k < 2; k++) begin
      got = obs(k); vectors++;
      if (got !== 10'b0) begin
        miscompares++;
        $display("[TB] FAIL reset_mid_mdu dut%0d: got %b expected %b", k, got, 10'b0);
      end
    end
    tick();
    @(negedge clock);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    #2;
    for (int k = 0; k < 2; k++) begin
      exp = model_out(k); got = obs(k); vectors++;
      if (got !== exp || got !== 10'b11111_0000_0) begin
        miscompares++;
        $display("[TB] FAIL after_reset dut%0d: got %b expected %b", k, got, 10'b11111_0000_0);
      end
    end
    tick();
  endtask

  // Random traffic with small register indices so hazards are frequent.
  task automatic test_random();
    logic [9:0] got, exp;
    for (int c = 0; c < 1500; c++) begin
      @(negedge clock);
      drive(($urandom_range(0, 2) == 0), 5'($urandom_range(0, 3)),
            5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 5) == 0), ($urandom_range(0, 4) == 0),
            ($urandom_range(0, 4) == 0));
      #2;
      for (int k = 0; k < 2; k++) begin
        exp = model_out(k); got = obs(k); vectors++;
        if (got !== exp) begin
          miscompares++;
          $display("[TB] FAIL random c%0d dut%0d: got %b expected %b", c, k, got, exp);
        end
      end
      tick();
    end
  endtask

`ifdef PIPE_HAZARD_STALL_CNT_EN
  // One load-use stall plus one MDU op: 1 + MDU_LAT stalled cycles.
  task automatic test_stall_cnt();
    @(negedge clock);
    reset = 1'b0;
    model_reset();
    tick();
    @(negedge clock);
    reset = 1'b1;
    drive(1, 5, 5, 0, 1, 0, 0, 0, 0);
    tick();
    @(negedge clock);
    drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
    tick();
    idle_cycles(6);
    #2;
    vectors++;
    if (stall4 !== 32'd5) begin
      miscompares++;
      $display("[TB] FAIL stall_cnt4: got %0d expected %0d", stall4, 5);
    end
    vectors++;
    if (stall2 !== 32'd3) begin
      miscompares++;
      $display("[TB] FAIL stall_cnt2: got %0d expected %0d", stall2, 3);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_load_use();
    idle_cycles(2);
    test_mdu();
    idle_cycles(2);
    test_branch_lu();
    idle_cycles(6);
    test_mem_wait_mdu();
    idle_cycles(6);
    test_reset_mid_mdu();
    test_random();
`ifdef PIPE_HAZARD_STALL_CNT_EN
    test_stall_cnt();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Hazard and sequencing controller for the 5-stage pipeline register chain: PC, IF/ID, ID/EX, EX/MEM, MEM/WB.
- Produces a per-stage load enable and a per-stage flush (bubble) for every pipeline register.
- Resolves four sources of disruption: load-use hazards, taken branches, a fixed-latency multi-cycle multiply/divide unit (MDU) and data-memory wait.
- Sits beside the datapath; flush forces the stage's next control word to all-zero, the same value as the register's reset state.

Parameters:
- REG_W, 5, register-index width.
- MDU_LAT, 4, total frozen cycles per MDU op; legal range 1..15.
- CNT_W, 4, MDU counter width; must satisfy 2^CNT_W > MDU_LAT.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- id_rs  in  REG_W  source register 1 of the instruction in ID.
- id_rt  in  REG_W  source register 2 of the instruction in ID.
- id_uses_rs  in  1  ID instruction reads rs.
- id_uses_rt  in  1  ID instruction reads rt.
- ex_mem_read  in  1  instruction in EX is a load.
- ex_rd  in  REG_W  destination register of the instruction in EX.
- branch_taken  in  1  branch or jump in EX resolved taken.
- mdu_start  in  1  instruction in EX is an MDU op.
- mem_wait  in  1  data memory not ready.
- pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en  out  1 each  stage load enables.
- if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush  out  1 each  load a bubble (zero control); the stage's en is 1 whenever its flush is 1.
- mdu_done  out  1  MDU result valid; the EX instruction advances this cycle.

Behaviour:
- All outputs are combinational from state and inputs.
- While reset=0: state=RUN, cnt=0, every *_en=0, every *_flush=0, mdu_done=0.
- Reset mid-MDU-op abandons the op.
- Default (no event): all en=1, all flush=0.
- Load-use condition (lu): ex_mem_read & ex_rd!=0 & ((id_uses_rs & id_rs==ex_rd) | (id_uses_rt & id_rt==ex_rd)).
- FSM states: RUN, MDU_BUSY, MDU_DONE. Per-cycle priority, highest first:
  1. mem_wait=1, any state: pc/if_id/id_ex/ex_mem en=0; mem_wb_flush=1. branch_taken, lu and mdu_start are ignored this cycle; they re-present next cycle because the stages are held.
  2. MDU freeze (RUN & mdu_start & !mem_wait, or state MDU_BUSY): pc/if_id/id_ex en=0; ex_mem_flush=1; mem_wb_en=1.
  3. branch_taken (RUN or MDU_DONE): all en=1; if_id_flush=1, id_ex_flush=1; PC loads the target. A simultaneous lu is suppressed because its ID instruction is killed.
  4. lu: pc_en=0, if_id_en=0, id_ex_flush=1; ex_mem and mem_wb advance.
- FSM transitions:
  - RUN & mdu_start & !mem_wait: cnt<=MDU_LAT-1; next state MDU_BUSY if MDU_LAT>1, else MDU_DONE.
  - MDU_BUSY: cnt decrements every cycle, regardless of mem_wait. When cnt==1, next state is MDU_DONE.
  - MDU_DONE: mdu_start ignored; mdu_done=!mem_wait; stays in MDU_DONE while mem_wait=1; otherwise next state RUN. Hazard rules 3 and 4 apply normally.
- Exactly MDU_LAT frozen cycles per op when mem_wait=0; mdu_done pulses for exactly one cycle per op.
- cnt never wraps; cnt is 0 whenever state=RUN.

Optional Feature:
- Macro: PIPE_HAZARD_STALL_CNT_EN.
- Defined: adds output stall_cycles (32 bits, reset 0). It increments on each clock where pc_en=0 while reset=1, and saturates at 0xFFFF_FFFF.
- Undefined: no port, no counter logic.

Test Plan:
- Load-use: ex_mem_read=1, ex_rd=5, id_rs=5, id_uses_rs=1 -> that cycle pc_en=0, if_id_en=0, id_ex_flush=1; next cycle, with ex_mem_read=0, all en=1. Repeat with ex_rd=0 -> no stall.
- MDU, MDU_LAT=4: mdu_start held from cycle 0 -> pc_en=0 and ex_mem_flush=1 in cycles 0-3; cycle 4 mdu_done=1, all en=1; cycle 5 state=RUN with mdu_start still 1 -> new op starts.
- Branch plus lu in the same cycle -> if_id_flush=1, id_ex_flush=1, pc_en=1; no lu stall.
- mem_wait=1 for 3 cycles during MDU_BUSY with MDU_LAT=2 -> FSM reaches MDU_DONE and holds; mdu_done=0 until mem_wait=0, then a single-cycle pulse; mem_wb_flush=1 during each wait cycle.
- reset driven low in cycle 2 of an MDU op -> all outputs 0 immediately; after release, state=RUN and default enables.
- With PIPE_HAZARD_STALL_CNT_EN: one lu stall plus one MDU op with MDU_LAT=4 -> stall_cycles=5.
